// File: rtl/audio_pwm_dac.sv
// ============================================================================
// audio_pwm_dac : sample FIFO feeding a 1-bit PWM (or sigma-delta) audio DAC.
// Optional macro AUDIO_SIGMA_DELTA_EN swaps the PWM compare for a 1st-order
// sigma-delta modulator.  Rev 1.0
// ============================================================================
`default_nettype none

module audio_pwm_dac #(
    parameter int PWM_BITS   = 8,
    parameter int REPEAT     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          enable,
    input  logic [15:0]                   in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          pwm_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;
    localparam logic [RW-1:0]       REP_MAX  = RW'(REPEAT - 1);
    localparam logic [AW:0]         LVL_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [PWM_BITS-1:0] MIDSCALE = {1'b1, {(PWM_BITS - 1){1'b0}}};

    logic [PWM_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]         level_q, level_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [RW-1:0]       rep_cnt_q, rep_cnt_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                underrun_q, underrun_d;

    logic                w_full, w_empty, w_push, w_load, w_pop;
    logic [15:0]         w_offset;
    logic [PWM_BITS-1:0] w_in_duty;
    logic                w_unused_lsbs;

    assign w_full  = (level_q == LVL_FULL);
    assign w_empty = (level_q == '0);
    assign w_push  = in_valid && !w_full;
    assign w_load  = enable && (pwm_cnt_q == CNT_MAX) && (rep_cnt_q == REP_MAX);
    // Pop decision uses pre-push occupancy, so a push landing on an empty
    // FIFO at the load point still counts as an underrun and stays queued.
    assign w_pop   = w_load && !w_empty;

    assign w_offset      = {~in_data[15], in_data[14:0]};
    assign w_in_duty     = w_offset[15 -: PWM_BITS];
    assign w_unused_lsbs = &{1'b0, in_data};

    always_comb begin
        wr_ptr_d   = w_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = w_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d    = level_q;
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + (AW + 1)'(1);
            2'b01:   level_d = level_q - (AW + 1)'(1);
            default: level_d = level_q;
        endcase
        pwm_cnt_d  = enable ? pwm_cnt_q + PWM_BITS'(1) : '0;
        rep_cnt_d  = rep_cnt_q;
        if (!enable)
            rep_cnt_d = '0;
        else if (pwm_cnt_q == CNT_MAX)
            rep_cnt_d = (rep_cnt_q == REP_MAX) ? '0 : rep_cnt_q + RW'(1);
        duty_d     = w_pop ? mem_q[rd_ptr_q] : duty_q;
        underrun_d = underrun_q | (w_load && w_empty);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            pwm_cnt_q  <= '0;
            rep_cnt_q  <= '0;
            duty_q     <= MIDSCALE;
            underrun_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            pwm_cnt_q  <= pwm_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            duty_q     <= duty_d;
            underrun_q <= underrun_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && w_push)
            mem_q[wr_ptr_q] <= w_in_duty;
    end

`ifdef AUDIO_SIGMA_DELTA_EN
    // The accumulator MSB is the registered carry, so it drives the pin directly.
    logic [PWM_BITS:0] acc_q, acc_d;

    always_comb begin
        acc_d = enable ? ({1'b0, acc_q[PWM_BITS-1:0]} + {1'b0, duty_q}) : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign pwm_out = acc_q[PWM_BITS];
`else
    logic pwm_q, pwm_d;

    always_comb begin
        pwm_d = enable && (pwm_cnt_q < duty_q);
    end

    always_ff @(posedge CLK) begin
        if (RST)
            pwm_q <= 1'b0;
        else
            pwm_q <= pwm_d;
    end

    assign pwm_out = pwm_q;
`endif

    assign in_ready   = !w_full;
    assign fifo_level = level_q;
    assign underrun   = underrun_q;

endmodule

`default_nettype wire
